// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - four-digit multiplexed seven-segment scan controller
//
// Scans four common-anode digits one at a time. Each digit slot is a run of
// GUARD dark cycles followed by REFRESH_DIV lit cycles. New data is captured
// into shadow registers on load and is only copied into the display registers
// at the end of a full frame, so a frame is never torn.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   load       - capture value/dp_in/blank_in into the shadow registers
//   value      - four hex nibbles, nibble k drives digit k (digit 0 rightmost)
//   dp_in      - decimal point enables, bit k for digit k
//   blank_in   - blank enables, bit k for digit k
//   D_seg      - segment bus, active-low {dp,g,f,e,d,c,b,a}
//   D_a        - digit anodes, active-low
//   pending    - shadow update captured but not yet on the display
//   frame_tick - one-cycle pulse on the first cycle of each new frame
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [7:0]  D_seg,
    output logic [3:0]  D_a,
    output logic        pending,
    output logic        frame_tick
);

    localparam int MAXC = (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);

    typedef enum logic {ST_GUARD, ST_SHOW} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_digit;

    logic [15:0]   r_shadow_val;
    logic [3:0]    r_shadow_dp;
    logic [3:0]    r_shadow_blank;
    logic [15:0]   r_disp_val;
    logic [3:0]    r_disp_dp;
    logic [3:0]    r_disp_blank;
    logic          r_pending;

    state_t        w_next_state;
    logic [CW-1:0] w_next_cnt;
    logic [1:0]    w_next_digit;
    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_dark;
    logic [3:0]    w_nib;
    logic [6:0]    w_hex;

    // Active-low segments g..a for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        w_slot_end   = (r_state == ST_GUARD) ? (r_cnt == GUARD_LAST) : (r_cnt == SHOW_LAST);
        w_frame_end  = (r_state == ST_SHOW) && (r_digit == 2'd3) && w_slot_end;
        w_next_state = r_state;
        w_next_digit = r_digit;
        w_next_cnt   = r_cnt + 1'b1;
        if (w_slot_end) begin
            w_next_cnt = '0;
            if (r_state == ST_GUARD) begin
                w_next_state = ST_SHOW;
            end else begin
                w_next_state = ST_GUARD;
                w_next_digit = r_digit + 2'd1;
            end
        end
        // Outputs are registered for the state being entered. Display registers
        // only change when entering a GUARD slot, which is dark anyway, so the
        // current display copy is always the right source here.
        w_nib  = r_disp_val[{w_next_digit, 2'b00} +: 4];
        w_hex  = hex7(w_nib);
        w_dark = (w_next_state == ST_GUARD) || r_disp_blank[w_next_digit];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_GUARD;
            r_cnt          <= '0;
            r_digit        <= 2'd0;
            r_shadow_val   <= 16'h0000;
            r_shadow_dp    <= 4'b0000;
            r_shadow_blank <= 4'b1111;
            r_disp_val     <= 16'h0000;
            r_disp_dp      <= 4'b0000;
            r_disp_blank   <= 4'b1111;
            r_pending      <= 1'b0;
            D_a            <= 4'b1111;
            D_seg          <= 8'hFF;
            frame_tick     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_digit    <= w_next_digit;
            frame_tick <= w_frame_end;

            if (w_dark) begin
                D_a   <= 4'b1111;
                D_seg <= 8'hFF;
            end else begin
                D_a   <= ~(4'b0001 << w_next_digit);
                D_seg <= {~r_disp_dp[w_next_digit], w_hex};
            end

            // A load on the boundary edge still applies the older shadow
            // (non-blocking read) and leaves the new capture pending.
            if (w_frame_end && r_pending) begin
                r_disp_val   <= r_shadow_val;
                r_disp_dp    <= r_shadow_dp;
                r_disp_blank <= r_shadow_blank;
            end
            if (load) begin
                r_shadow_val   <= value;
                r_shadow_dp    <= dp_in;
                r_shadow_blank <= blank_in;
            end
            r_pending <= load | (r_pending & ~w_frame_end);
        end
    end

    assign pending = r_pending;

endmodule
